// File: rtl/ula_operand_sequencer.sv
// ula_operand_sequencer
// Collects operand A, operand B and the ALU select from switches, one value per
// press of the enter button. It then captures the external ALU's result and
// overflow bit and shows them until the next press.
// Optional feature: define ACC_CHAIN_EN to chain the accumulator. A press while
// the result is shown then copies the result into operand A and resumes at
// operand B.
module ula_operand_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic [1:0]       op_in,
   input  logic             enter,
   input  logic [WIDTH-1:0] alu_s,
   input  logic             alu_ovf,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_sel,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             done,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   state_t state;
   state_t next_state;

   logic enter_q;
   logic enter_edge;
   logic load_a;
   logic load_b;
   logic load_sel;
   logic capture;
`ifdef ACC_CHAIN_EN
   logic chain_a;
`endif

   // The button is a level; a press counts once, on the cycle it first reads high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enter_q <= 1'b0;
      end else begin
         enter_q <= enter;
      end
   end

   assign enter_edge = enter & ~enter_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_A;
      end else begin
         state <= next_state;
      end
   end

   // Advance one step per press; the execute step always takes exactly one cycle
   always_comb begin
      next_state = state;
      case (state)
         S_A:    if (enter_edge) next_state = S_B;
         S_B:    if (enter_edge) next_state = S_OP;
         S_OP:   if (enter_edge) next_state = S_EXEC;
         S_EXEC: next_state = S_SHOW;
         S_SHOW: begin
`ifdef ACC_CHAIN_EN
            if (enter_edge) next_state = S_B;
`else
            if (enter_edge) next_state = S_A;
`endif
         end
         default: next_state = S_A;
      endcase
   end

   // Decode the current step into register load strobes and the status outputs
   always_comb begin
      load_a   = 1'b0;
      load_b   = 1'b0;
      load_sel = 1'b0;
      capture  = 1'b0;
      done     = 1'b0;
`ifdef ACC_CHAIN_EN
      chain_a  = 1'b0;
`endif
      case (state)
         S_A:    load_a   = enter_edge;
         S_B:    load_b   = enter_edge;
         S_OP:   load_sel = enter_edge;
         S_EXEC: capture  = 1'b1;
         S_SHOW: begin
            done = 1'b1;
`ifdef ACC_CHAIN_EN
            chain_a = enter_edge;
`endif
         end
         default: ;
      endcase
   end

   assign state_o = state;

   // Operand and select registers feeding the ALU; they hold until reloaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= 2'd0;
      end else begin
         if (load_a) begin
            alu_a <= data_in;
         end
`ifdef ACC_CHAIN_EN
         else if (chain_a) begin
            alu_a <= result;
         end
`endif
         if (load_b) begin
            alu_b <= data_in;
         end
         if (load_sel) begin
            alu_sel <= op_in;
         end
      end
   end

   // Capture the ALU's answer exactly as returned, once per execute step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         ovf    <= 1'b0;
      end else if (capture) begin
         result <= alu_s;
         ovf    <= alu_ovf;
      end
   end

endmodule
